// File: rtl/biriscv_decode_queue_pkg.sv
// Shared core definitions for the fetch-to-decode queue: default depth,
// the NOP substituted for faulting fetches, and the stored entry layout.
package biriscv_decode_queue_pkg;

  localparam int          DQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } dq_entry_t;

  // A faulting fetch carries no usable opcode, so the decoder sees a NOP
  // and relies on the fault flag to raise the exception.
  function automatic dq_entry_t make_entry(input logic [31:0] pc,
                                           input logic [31:0] instr,
                                           input logic        fault);
    dq_entry_t e;
    e.pc    = pc;
    e.instr = fault ? NOP_INSTR : instr;
    e.fault = fault;
    return e;
  endfunction

endpackage

// File: rtl/biriscv_decode_queue.sv
// Circular instruction queue between fetch and decode. Head is presented from
// storage, so a pushed entry is visible one cycle later at the earliest.
module biriscv_decode_queue
  import biriscv_decode_queue_pkg::*;
#(
  parameter int DEPTH = DQ_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [31:0]              fetch_instr_i,
  input  logic                     fetch_fault_i,
  output logic                     fetch_accept_o,
  input  logic                     branch_request_i,
  output logic                     decode_valid_o,
  output logic [31:0]              decode_pc_o,
  output logic [31:0]              decode_instr_o,
  output logic                     decode_fault_o,
  input  logic                     decode_accept_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

  dq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_w;
  logic             pop_w;
  dq_entry_t        head_w;

  // Accept depends only on registered occupancy, keeping fetch off the
  // decode/branch timing paths.
  assign fetch_accept_o = (count_q != FULL_COUNT);
  assign decode_valid_o = (count_q != '0);

  assign push_w = fetch_valid_i  && fetch_accept_o  && !branch_request_i;
  assign pop_w  = decode_valid_o && decode_accept_i && !branch_request_i;

  // NOTE: the storage array has no reset so it can map onto distributed RAM;
  // count_q alone decides which entries are live, so stale contents are harmless.
  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_ptr_q] <= make_entry(fetch_pc_i, fetch_instr_i, fetch_fault_i);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || branch_request_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_w, pop_w})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_w         = mem_q[rd_ptr_q];
  assign decode_pc_o    = decode_valid_o ? head_w.pc    : 32'h0;
  assign decode_instr_o = decode_valid_o ? head_w.instr : 32'h0;
  assign decode_fault_o = decode_valid_o ? head_w.fault : 1'b0;
  assign level_o        = count_q;

endmodule

// File: tb/tb_biriscv_decode_queue.sv
// Self-checking bench: a queue-based scoreboard predicts every decode output
// each cycle, plus directed checks on the documented scenarios.
module tb_biriscv_decode_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic                   fetch_valid_i;
  logic [31:0]            fetch_pc_i;
  logic [31:0]            fetch_instr_i;
  logic                   fetch_fault_i;
  logic                   fetch_accept_o;
  logic                   branch_request_i;
  logic                   decode_valid_o;
  logic [31:0]            decode_pc_o;
  logic [31:0]            decode_instr_o;
  logic                   decode_fault_o;
  logic                   decode_accept_i;
  logic [$clog2(DEPTH):0] level_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  biriscv_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_pc_i       (fetch_pc_i),
    .fetch_instr_i    (fetch_instr_i),
    .fetch_fault_i    (fetch_fault_i),
    .fetch_accept_o   (fetch_accept_o),
    .branch_request_i (branch_request_i),
    .decode_valid_o   (decode_valid_o),
    .decode_pc_o      (decode_pc_o),
    .decode_instr_o   (decode_instr_o),
    .decode_fault_o   (decode_fault_o),
    .decode_accept_i  (decode_accept_i),
    .level_o          (level_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the scoreboard, then clock one cycle and
  // advance the scoreboard by what the queue should have done on that edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic f, input logic da, input logic br, input logic r);
    int   sz;
    exp_t e;
    fetch_valid_i    = v;
    fetch_pc_i       = pc;
    fetch_instr_i    = ins;
    fetch_fault_i    = f;
    decode_accept_i  = da;
    branch_request_i = br;
    rst_i            = r;
    #1;
    sz = sb.size();
    check("decode_valid", 32'(decode_valid_o), 32'(sz != 0));
    check("level", 32'(level_o), 32'(sz));
    check("fetch_accept", 32'(fetch_accept_o), 32'(sz != DEPTH));
    if (sz != 0) begin
      check("decode_pc", decode_pc_o, sb[0].pc);
      check("decode_instr", decode_instr_o, sb[0].instr);
      check("decode_fault", 32'(decode_fault_o), 32'(sb[0].fault));
    end else begin
      check("idle_pc", decode_pc_o, 32'h0);
      check("idle_instr", decode_instr_o, 32'h0);
      check("idle_fault", 32'(decode_fault_o), 32'h0);
    end
    if (r || br) begin
      sb.delete();
    end else begin
      if (da && sz != 0) void'(sb.pop_front());
      if (v && sz != DEPTH) begin
        e.pc    = pc;
        e.instr = f ? 32'h0000_0013 : ins;
        e.fault = f;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    cycle(1'b1, pc, ins, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    fetch_valid_i = 1'b0; fetch_pc_i = '0; fetch_instr_i = '0; fetch_fault_i = 1'b0;
    decode_accept_i = 1'b0; branch_request_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(decode_valid_o), 32'h0);
    check("rst_level", 32'(level_o), 32'h0);
    check("rst_accept", 32'(fetch_accept_o), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // First push visible next cycle.
    push(32'h8000_0000, 32'h0050_0093);
    check("first_valid", 32'(decode_valid_o), 32'h1);
    check("first_pc", decode_pc_o, 32'h8000_0000);
    check("first_instr", decode_instr_o, 32'h0050_0093);
    check("first_level", 32'(level_o), 32'h1);
    pop();

    // Fill past capacity with decode stalled; pointers start at 1 so the fill wraps.
    for (int i = 0; i < 5; i++) push(32'h1000 + 32'(i) * 4, 32'hA000_0000 + 32'(i));
    check("full_level", 32'(level_o), 32'h4);
    check("full_accept", 32'(fetch_accept_o), 32'h0);
    repeat (3) idle();  // stalled head must stay put
    for (int i = 0; i < 4; i++) begin
      check("drain_order_pc", decode_pc_o, 32'h1000 + 32'(i) * 4);
      pop();
    end
    check("drained_valid", 32'(decode_valid_o), 32'h0);

    // Steady push+pop at level 2 across many wraps.
    push(32'h2000, 32'h1);
    push(32'h2004, 32'h2);
    for (int i = 2; i < 22; i++) begin
      check("steady_pc", decode_pc_o, 32'h2000 + 32'(i - 2) * 4);
      cycle(1'b1, 32'h2000 + 32'(i) * 4, 32'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0);
      check("steady_level", 32'(level_o), 32'h2);
    end
    pop(); pop();

    // Faulting fetch stores a NOP with the fault flag.
    cycle(1'b1, 32'h3000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fault_instr", decode_instr_o, 32'h0000_0013);
    check("fault_flag", 32'(decode_fault_o), 32'h1);
    pop();

    // Branch flush with a concurrent push discards everything.
    for (int i = 0; i < 3; i++) push(32'h4000 + 32'(i) * 4, 32'hB0 + 32'(i));
    cycle(1'b1, 32'h4100, 32'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_valid", 32'(decode_valid_o), 32'h0);
    check("flush_level", 32'(level_o), 32'h0);
    idle();

    // Reset mid-stream beats a concurrent push.
    push(32'h5000, 32'hC0);
    push(32'h5004, 32'hC1);
    cycle(1'b1, 32'h5008, 32'hC2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_level", 32'(level_o), 32'h0);
    check("midrst_valid", 32'(decode_valid_o), 32'h0);
    check("midrst_accept", 32'(fetch_accept_o), 32'h1);
    push(32'h6000, 32'hD0);
    check("postrst_pc", decode_pc_o, 32'h6000);
    pop();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
